// File: rtl/mux4_select_sequencer.sv
// mux4_select_sequencer: round-robin select sequencer for a 4:1 mux. It drives
//   {s2,s1}, waits DWELL settle cycles, samples mux_in and offers {sample_ch, sample_bit}.
// Latency: sample_valid rises DWELL clocks after the start or advance edge. All outputs are registered.
// Backpressure: the sample, its channel and the selects hold while sample_valid & !sample_ready.
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   start, stop           control pulses (stop finishes the in-flight sample first)
//   en_mask[3:0]          channel enables (bit0=a .. bit3=d)
//   mux_in                mux output fed back for sampling
//   s1, s2                registered selects, {s2,s1} = channel index
//   sample_bit/_ch/_valid sample offered to consumer; sample_ready accepts it
//   busy                  high whenever not idle
// Optional: define MUX_SEQ_COUNT_EN to add sample_count[7:0], a wrapping count of accepted samples.
module mux4_select_sequencer #(
    parameter int unsigned DWELL = 4    // settle cycles, legal range 1..255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       stop,
    input  logic [3:0] en_mask,
    input  logic       mux_in,
    output logic       s1,
    output logic       s2,
    output logic       sample_bit,
    output logic [1:0] sample_ch,
    output logic       sample_valid,
    input  logic       sample_ready,
    output logic       busy
`ifdef MUX_SEQ_COUNT_EN
    ,
    output logic [7:0] sample_count
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HOLD   = 2'd2
    } state_t;

    state_t     state;
    logic [1:0] ptr;        // where the next channel search begins
    logic [7:0] cnt;        // settle counter
    logic       stop_pend;  // stop seen while busy; honoured at the next accept

    localparam logic [7:0] CNT_LAST = 8'(DWELL - 1);

    // First enabled channel scanning x, x+1, ... (mod 4). The scan runs from the
    // farthest offset down so the nearest enabled channel wins. The result is
    // only used when m != 0.
    function automatic logic [1:0] next_ch(input logic [1:0] x, input logic [3:0] m);
        logic [1:0] c;
        next_ch = x;
        for (int i = 3; i >= 0; i--) begin
            c = x + 2'(i);
            if (m[c]) next_ch = c;
        end
    endfunction

    logic accept;
    assign accept = sample_valid & sample_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            ptr          <= 2'd0;
            cnt          <= 8'd0;
            stop_pend    <= 1'b0;
            s1           <= 1'b0;
            s2           <= 1'b0;
            sample_bit   <= 1'b0;
            sample_ch    <= 2'd0;
            sample_valid <= 1'b0;
            busy         <= 1'b0;
`ifdef MUX_SEQ_COUNT_EN
            sample_count <= 8'd0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    // stop beats start; an empty mask makes start a no-op
                    if (start && !stop && (en_mask != 4'd0)) begin
                        {s2, s1} <= next_ch(ptr, en_mask);
                        cnt      <= 8'd0;
                        busy     <= 1'b1;
                        state    <= SETTLE;
                    end
                end

                SETTLE: begin
                    if (stop) stop_pend <= 1'b1;
                    if (cnt == CNT_LAST) begin
                        sample_bit   <= mux_in;
                        sample_ch    <= {s2, s1};
                        sample_valid <= 1'b1;
                        state        <= HOLD;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end

                HOLD: begin
                    if (stop) stop_pend <= 1'b1;
                    if (accept) begin
                        sample_valid <= 1'b0;
                        ptr          <= sample_ch + 2'd1;
`ifdef MUX_SEQ_COUNT_EN
                        sample_count <= sample_count + 8'd1;
`endif
                        // A stop arriving on the accept edge also ends the scan.
                        // In that case the selects keep the last channel.
                        if (stop_pend || stop || (en_mask == 4'd0)) begin
                            state     <= IDLE;
                            busy      <= 1'b0;
                            stop_pend <= 1'b0;
                        end else begin
                            {s2, s1} <= next_ch(sample_ch + 2'd1, en_mask);
                            cnt      <= 8'd0;
                            state    <= SETTLE;
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mux4_select_sequencer.sv
// tb_mux4_select_sequencer: directed self-checking bench for mux4_select_sequencer.
// Latency: the mux model is combinational from {s2,s1}; channel k returns data_pat[k].
// Backpressure: sample_ready is driven per scenario by the bench.
module tb_mux4_select_sequencer;

    localparam int DWELL = 4;

    logic       clk = 1'b0;
    logic       reset, start, stop, mux_in, sample_ready;
    logic [3:0] en_mask;
    logic       s1, s2, sample_bit, sample_valid, busy;
    logic [1:0] sample_ch;
    logic [3:0] data_pat = 4'b1010;  // channel k returns k[0]
`ifdef MUX_SEQ_COUNT_EN
    logic [7:0] sample_count;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    logic [1:0] got_ch  [0:15];
    logic       got_bit [0:15];
    int         got_n;
    int         first_lat;

    always #5 clk = ~clk;

    assign mux_in = data_pat[{s2, s1}];

    mux4_select_sequencer #(.DWELL(DWELL)) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .en_mask(en_mask),
        .mux_in(mux_in), .s1(s1), .s2(s2), .sample_bit(sample_bit),
        .sample_ch(sample_ch), .sample_valid(sample_valid),
        .sample_ready(sample_ready), .busy(busy)
`ifdef MUX_SEQ_COUNT_EN
        , .sample_count(sample_count)
`endif
    );

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; start = 1'b0; stop = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    // Records each sample offered with ready high; returns on the negedge of the last one.
    task automatic collect(input int n, input int budget);
        int cyc;
        cyc = 0; got_n = 0; first_lat = -1;
        while (got_n < n && cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (sample_valid && sample_ready) begin
                if (first_lat < 0) first_lat = cyc;
                if (got_n < 16) begin
                    got_ch[got_n]  = sample_ch;
                    got_bit[got_n] = sample_bit;
                end
                n_cmp++;
                if ({s2, s1} !== sample_ch) begin
                    n_fail++;
                    $display("FAIL sel_vs_ch: sel=%0d required %0d", {s2, s1}, sample_ch);
                end
                got_n++;
            end
        end
        n_cmp++;
        if (got_n != n) begin
            n_fail++;
            $display("FAIL collect_timeout: got %0d samples required %0d", got_n, n);
        end
    endtask

    // Waits for sample_valid regardless of ready; returns at that negedge.
    task automatic wait_valid(input string name);
        int cyc;
        cyc = 0;
        while (!sample_valid && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        n_cmp++;
        if (!sample_valid) begin
            n_fail++;
            $display("FAIL %s_timeout: sample_valid=%b required 1", name, sample_valid);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1; start = 1'b0; stop = 1'b0; en_mask = 4'b0000; sample_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if ({s2, s1, sample_bit, sample_ch, sample_valid, busy} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: s2s1=%b bit=%b ch=%0d vld=%b busy=%b required all 0",
                     {s2, s1}, sample_bit, sample_ch, sample_valid, busy);
        end
`ifdef MUX_SEQ_COUNT_EN
        n_cmp++;
        if (sample_count !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_count: %0d required 0", sample_count);
        end
`endif
        reset = 1'b0;
        pulse_start();
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (busy !== 1'b0) begin
                n_fail++;
                $display("FAIL empty_mask_start: busy=%b required 0", busy);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_basic_scan();
        logic [1:0] exp_ch [0:4];
        exp_ch = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        do_reset();
        en_mask = 4'b1111; sample_ready = 1'b1;
        pulse_start();
        collect(5, 60);
        n_cmp++;
        if (first_lat != DWELL) begin
            n_fail++;
            $display("FAIL first_latency: %0d clocks required %0d", first_lat, DWELL);
        end
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if (got_ch[i] !== exp_ch[i] || got_bit[i] !== exp_ch[i][0]) begin
                n_fail++;
                $display("FAIL basic_sample%0d: ch=%0d bit=%b required ch=%0d bit=%b",
                         i, got_ch[i], got_bit[i], exp_ch[i], exp_ch[i][0]);
            end
        end
    endtask

    task automatic test_sparse_mask();
        logic [1:0] exp_ch [0:3];
        exp_ch = '{2'd1, 2'd3, 2'd1, 2'd3};
        do_reset();
        en_mask = 4'b1010; sample_ready = 1'b1;
        pulse_start();
        collect(4, 60);
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (got_ch[i] !== exp_ch[i]) begin
                n_fail++;
                $display("FAIL sparse_sample%0d: ch=%0d required %0d", i, got_ch[i], exp_ch[i]);
            end
        end
        // single enabled channel is resampled every time
        do_reset();
        en_mask = 4'b0100;
        pulse_start();
        collect(3, 40);
        n_cmp++;
        if (got_ch[0] !== 2'd2 || got_ch[1] !== 2'd2 || got_ch[2] !== 2'd2) begin
            n_fail++;
            $display("FAIL single_channel: ch=%0d,%0d,%0d required 2,2,2",
                     got_ch[0], got_ch[1], got_ch[2]);
        end
    endtask

    task automatic test_backpressure();
        logic       stable;
        logic [4:0] snap;
        do_reset();
        en_mask = 4'b1111; sample_ready = 1'b0;
        pulse_start();
        wait_valid("bp_first");
        snap = {sample_valid, sample_bit, sample_ch, s2 ^ s1};
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if ({sample_valid, sample_bit, sample_ch, s2 ^ s1} !== snap || {s2, s1} !== 2'd0)
                stable = 1'b0;
        end
        n_cmp++;
        if (stable !== 1'b1 || snap !== 5'b1_0_00_0) begin
            n_fail++;
            $display("FAIL bp_hold: stable=%b snap=%b required stable=1 snap=10000", stable, snap);
        end
        sample_ready = 1'b1;
        @(negedge clk);
        sample_ready = 1'b0;
        n_cmp++;
        if (sample_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_single_accept: sample_valid=%b required 0", sample_valid);
        end
        wait_valid("bp_next");
        n_cmp++;
        if (sample_ch !== 2'd1) begin
            n_fail++;
            $display("FAIL bp_next_ch: ch=%0d required 1", sample_ch);
        end
    endtask

    task automatic test_stop_restart();
        do_reset();
        en_mask = 4'b1111; sample_ready = 1'b1;
        pulse_start();
        collect(2, 40);          // channels 0 and 1; ch 1 is accepted on the next edge
        @(negedge clk);          // now settling on ch 2
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        wait_valid("stop_inflight");
        n_cmp++;
        if (sample_ch !== 2'd2) begin
            n_fail++;
            $display("FAIL stop_inflight_ch: ch=%0d required 2", sample_ch);
        end
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || sample_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL stop_idle: busy=%b vld=%b required 0 0", busy, sample_valid);
        end
        pulse_start();
        collect(1, 20);
        n_cmp++;
        if (got_ch[0] !== 2'd3) begin
            n_fail++;
            $display("FAIL restart_ch: ch=%0d required 3", got_ch[0]);
        end
    endtask

    task automatic test_start_stop_same();
        do_reset();
        en_mask = 4'b1111; sample_ready = 1'b1;
        @(negedge clk); start = 1'b1; stop = 1'b1;
        @(negedge clk); start = 1'b0; stop = 1'b0;
        for (int i = 0; i < DWELL + 2; i++) begin
            n_cmp++;
            if (busy !== 1'b0 || sample_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL start_stop_same: busy=%b vld=%b required 0 0", busy, sample_valid);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_in_hold();
        do_reset();
        en_mask = 4'b1111; sample_ready = 1'b1;
        pulse_start();
        collect(1, 20);          // ch 0 accepted on next edge, ptr moves to 1
        @(negedge clk);
        sample_ready = 1'b0;
        wait_valid("hold_ch1");
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_cmp++;
        if (sample_valid !== 1'b0 || busy !== 1'b0 || {s2, s1} !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_in_hold: vld=%b busy=%b sel=%0d required 0 0 0",
                     sample_valid, busy, {s2, s1});
        end
        sample_ready = 1'b1;
        pulse_start();
        collect(1, 20);
        n_cmp++;
        if (got_ch[0] !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_ptr: first ch=%0d required 0", got_ch[0]);
        end
    endtask

`ifdef MUX_SEQ_COUNT_EN
    task automatic test_sample_count();
        do_reset();
        en_mask = 4'b1111; sample_ready = 1'b1;
        pulse_start();
        collect(260, 260 * (DWELL + 2));
        @(negedge clk);
        n_cmp++;
        if (sample_count !== 8'd4) begin
            n_fail++;
            $display("FAIL sample_count_wrap: %0d required 4", sample_count);
        end
    endtask
`endif

    initial begin
        reset = 1'b1; start = 1'b0; stop = 1'b0; en_mask = 4'b0000; sample_ready = 1'b0;
        test_reset();
        test_basic_scan();
        test_sparse_mask();
        test_backpressure();
        test_stop_restart();
        test_start_stop_same();
        test_reset_in_hold();
`ifdef MUX_SEQ_COUNT_EN
        test_sample_count();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
